data_mem_ctrl: RTL and testbench

Parametrised data memory with a valid/ready request port and a fixed-latency response port. Replaces the single-cycle word-only data memory in the processor's memory stage. Adds byte/halfword/word stores with lane masking, sign/zero-extending loads, alignment and range checking, and configurable wait states. Keeps the word-0 debug tap.

---
 rtl/data_mem_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data memory with a valid/ready request port and a
// fixed-latency response port. Supports byte/half/word stores with lane
// masking, sign/zero-extending loads, alignment/range checking and a
// word-0 debug tap.
// Optional feature macro: DMEM_CLEAR_EN. When defined, the array is swept
// to zero, one word per cycle, after every reset release.
module data_mem_ctrl #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       dm0
);

  localparam int IDX_W = $clog2(DEPTH);
  // Counter serves both the latency count and the clear sweep index.
  localparam int CNT_W = (IDX_W > 4) ? IDX_W : 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2
`ifdef DMEM_CLEAR_EN
    ,S_CLEAR = 2'd3
`endif
  } state_t;

`ifdef DMEM_CLEAR_EN
  localparam state_t RESET_STATE = S_CLEAR;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  logic [31:0]      r_mem [DEPTH];
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_err;

  logic             w_accept;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic             w_oor;
  logic             w_err;
  logic [31:0]      w_rd_word;
  logic [31:0]      w_shifted;
  logic [31:0]      w_load;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_rep;
  logic [31:0]      w_merged;
  logic             w_mem_we;
  logic [IDX_W-1:0] w_mem_idx;
  logic [31:0]      w_mem_wdata;

  assign w_idx     = req_addr[IDX_W+1:2];
  assign w_lane    = req_addr[1:0];
  // Any set bit above the index field means the word index is >= DEPTH.
  assign w_oor     = |(req_addr[ADDR_W-1:2] >> IDX_W);
  assign w_rd_word = r_mem[w_idx];
  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign dm0       = r_mem[0];
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // Request legality: range, size encoding and natural alignment.
  always_comb begin
    w_err = w_oor;
    case (req_size)
      2'b01:   if (w_lane[0]) w_err = 1'b1;
      2'b10:   if (w_lane != 2'b00) w_err = 1'b1;
      2'b11:   w_err = 1'b1;
      default: ;
    endcase
  end

  // Lane enables and lane-replicated store data.
  always_comb begin
    w_be        = 4'b1111;
    w_wdata_rep = req_wdata;
    case (req_size)
      2'b00: begin
        w_be        = 4'b0001 << w_lane;
        w_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Merge new lanes over the currently stored word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_merged[gi*8 +: 8] = w_be[gi] ? w_wdata_rep[gi*8 +: 8] : w_rd_word[gi*8 +: 8];
    end
  endgenerate

  // Load lane extraction and sign/zero extension; a half is always aligned so a
  // byte-granular shift also selects the correct halfword.
  always_comb begin
    w_shifted = w_rd_word >> {w_lane, 3'b000};
    case (req_size)
      2'b00:   w_load = {{24{~req_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = {{16{~req_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_rd_word;
    endcase
  end

  // Array write port selection: clear sweep or committed store; never during reset.
  always_comb begin
    w_mem_we    = w_accept && req_we && !w_err && !rst;
    w_mem_idx   = w_idx;
    w_mem_wdata = w_merged;
`ifdef DMEM_CLEAR_EN
    if (r_state == S_CLEAR) begin
      w_mem_we    = !rst;
      w_mem_idx   = r_cnt[IDX_W-1:0];
      w_mem_wdata = '0;
    end
`endif
  end

  // Memory array write (contents are not reset).
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RESET_STATE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // FSM next state, counter update and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 1) begin
            w_state_next = S_RESP;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_W'(LATENCY - 1)) w_state_next = S_RESP;
        else                              w_cnt_next   = r_cnt + 1'b1;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_next = S_IDLE;
      end
`ifdef DMEM_CLEAR_EN
      S_CLEAR: begin
        if (r_cnt == CNT_W'(DEPTH - 1)) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // Response registers captured at the acceptance edge and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_rdata <= (w_err || req_we) ? 32'h0 : w_load;
      r_rsp_err   <= w_err;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: behavioural memory model plus a
// per-cycle compare process, directed literal checks and random traffic.
module tb_data_mem_ctrl;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata, dm0;

  int n_checks = 0;
  int n_errors = 0;

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dm0(dm0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc    = 0;
  bit          m_busy = 0;
  int          m_due  = 0;
  int          m_clr  = 0;
  logic [31:0] m_rdata = 0;
  logic        m_err   = 0;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];

  task automatic model_accept();
    int unsigned idx;
    int          lane;
    logic [31:0] mask, val;
    idx  = 32'(req_addr[31:2]);
    lane = int'(req_addr[1:0]);
    m_err = (idx >= DEPTH) || (req_size == 2'b11) ||
            (req_size == 2'b01 && (lane % 2) != 0) ||
            (req_size == 2'b10 && lane != 0);
    m_rdata = 0;
    if (!m_err) begin
      if (req_we) begin
        if (req_size == 2'b10) begin
          m_mem[idx]   = req_wdata;
          m_known[idx] = 1;
        end else begin
          mask = (req_size == 2'b00) ? 32'hFF : 32'hFFFF;
          m_mem[idx] = (m_mem[idx] & ~(mask << (8 * lane))) | ((req_wdata & mask) << (8 * lane));
        end
      end else begin
        val = m_mem[idx] >> (8 * lane);
        if (req_size == 2'b00) begin
          val = val % 256;
          m_rdata = (!req_unsigned && val >= 128) ? val + 32'hFFFFFF00 : val;
        end else if (req_size == 2'b01) begin
          val = val % 65536;
          m_rdata = (!req_unsigned && val >= 32768) ? val + 32'hFFFF0000 : val;
        end else begin
          m_rdata = m_mem[idx];
        end
      end
    end
  endtask

  // Model update on each edge; reset aborts any outstanding request.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0;
`ifdef DMEM_CLEAR_EN
      m_clr = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]   = 0;
        m_known[i] = 1;
      end
`endif
    end else begin
      cyc++;
      if (m_clr > 0) m_clr--;
      else if (m_busy) begin
        if (cyc >= m_due && rsp_ready) m_busy = 0;
      end else if (req_valid) begin
        model_accept();
        m_busy = 1;
        m_due  = cyc + LAT;
      end
    end
  end

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_v;
      exp_v = m_busy && (cyc >= m_due - 1);
      chk("req_ready", 32'(req_ready), 32'(!m_busy && m_clr == 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
      end
      if (m_known[0]) chk("dm0", dm0, m_mem[0]);
    end
  end

  // ---------------- driver ----------------
  int txn = 0;

  // Called at a negedge; returns at the negedge after the retiring edge.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic err, output int lat);
    int g;
    rd = 0; err = 0; lat = 0;
    g = 0;
    while (!req_ready && g < 200) begin @(negedge clk); g++; end
    if (!req_ready) begin
      n_checks++; n_errors++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 200 cycles");
      return;
    end
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
    rsp_ready = 0; req_valid = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin
      n_checks++; n_errors++;
      $display("FAIL rsp_timeout: got rsp_valid=0 expected 1 within 50 cycles");
      return;
    end
    rd = rsp_rdata; err = rsp_err;
    repeat (hold) @(negedge clk);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    $display("txn %0d we=%0d addr=%08h size=%0d uns=%0d wdata=%08h rdata=%08h err=%0d lat=%0d",
             txn, we, addr, size, uns, wd, rd, err, lat);
    txn++;
  endtask

  logic [31:0] init_data [DEPTH];

  initial begin
    logic [31:0] rd, rd0;
    logic        er;
    int          lat;
    int          k;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    req_valid = 0; req_we = 0; req_addr = 0; req_size = 0; req_unsigned = 0;
    req_wdata = 0; rsp_ready = 0;
    rst = 0;
    #1 rst = 1;
    repeat (2) @(negedge clk);
`ifdef DMEM_CLEAR_EN
    chk("reset_req_ready", 32'(req_ready), 32'h0);
`else
    chk("reset_req_ready", 32'(req_ready), 32'h1);
`endif
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    #2 rst = 0;
    @(negedge clk);

`ifdef DMEM_CLEAR_EN
    k = 1;
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    chk("clear_cycles", 32'(k), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      do_req(0, 32'(i * 4), 2'b10, 0, 0, 0, rd, er, lat);
      chk("clear_load", rd, 32'h0);
    end
`endif

    // Fill the whole array with known data.
    for (int i = 0; i < DEPTH; i++) begin
      init_data[i] = $urandom;
      do_req(1, 32'(i * 4), 2'b10, 0, init_data[i], 0, rd, er, lat);
    end

    // Word store/load with latency and dm0 untouched.
    do_req(1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 0, rd, er, lat);
    chk("store_lat", 32'(lat), 32'(LAT));
    chk("store_rdata", rd, 32'h0);
    do_req(0, 32'h10, 2'b10, 0, 0, 0, rd, er, lat);
    chk("load_deadbeef", rd, 32'hDEADBEEF);
    chk("load_err", 32'(er), 32'h0);
    chk("load_lat", 32'(lat), 32'(LAT));
    chk("dm0_unchanged", dm0, init_data[0]);

    // Byte and half lanes with extension.
    do_req(1, 32'h10, 2'b10, 0, 32'h11223344, 0, rd, er, lat);
    do_req(1, 32'h13, 2'b00, 0, 32'hFFFFFF80, 1, rd, er, lat);
    do_req(0, 32'h10, 2'b10, 0, 0, 0, rd, er, lat);
    chk("byte_merge", rd, 32'h80223344);
    do_req(0, 32'h13, 2'b00, 0, 0, 2, rd, er, lat);
    chk("lb_signed", rd, 32'hFFFFFF80);
    do_req(0, 32'h13, 2'b00, 1, 0, 0, rd, er, lat);
    chk("lb_unsigned", rd, 32'h00000080);
    do_req(0, 32'h12, 2'b01, 0, 0, 0, rd, er, lat);
    chk("lh_signed", rd, 32'hFFFF8022);
    do_req(0, 32'h12, 2'b01, 1, 0, 0, rd, er, lat);
    chk("lh_unsigned", rd, 32'h00008022);
    do_req(1, 32'h12, 2'b01, 0, 32'h0000ABCD, 0, rd, er, lat);
    do_req(0, 32'h10, 2'b10, 1, 0, 0, rd, er, lat);
    chk("half_merge", rd, 32'hABCD3344);

    // dm0 tap.
    do_req(1, 32'h0, 2'b10, 0, 32'hCAFEF00D, 0, rd, er, lat);
    chk("dm0_store", dm0, 32'hCAFEF00D);

    // Error cases, loads then stores.
    do_req(0, 32'h01, 2'b01, 0, 0, 0, rd, er, lat);
    chk("err_half_mis", 32'(er), 32'h1);  chk("err_half_mis_rd", rd, 32'h0);
    do_req(0, 32'h02, 2'b10, 0, 0, 0, rd, er, lat);
    chk("err_word_mis", 32'(er), 32'h1);  chk("err_word_mis_rd", rd, 32'h0);
    do_req(0, 32'h04, 2'b11, 0, 0, 0, rd, er, lat);
    chk("err_size", 32'(er), 32'h1);      chk("err_size_rd", rd, 32'h0);
    do_req(0, 32'(4 * DEPTH), 2'b10, 0, 0, 0, rd, er, lat);
    chk("err_range", 32'(er), 32'h1);     chk("err_range_rd", rd, 32'h0);
    do_req(1, 32'h01, 2'b01, 0, 32'hFFFFFFFF, 0, rd, er, lat);
    do_req(1, 32'h02, 2'b10, 0, 32'hFFFFFFFF, 0, rd, er, lat);
    do_req(1, 32'h00, 2'b11, 0, 32'hFFFFFFFF, 0, rd, er, lat);
    do_req(1, 32'(4 * DEPTH), 2'b10, 0, 32'hFFFFFFFF, 0, rd, er, lat);
    chk("err_store_err", 32'(er), 32'h1);
    do_req(0, 32'h00, 2'b10, 0, 0, 0, rd, er, lat);
    chk("err_store_nowrite", rd, 32'hCAFEF00D);

    // Backpressure: response held, second request refused.
    do_req(1, 32'h20, 2'b10, 0, 32'h600DF00D, 0, rd, er, lat);
    req_we = 0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 0; req_valid = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    k = 1;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    rd0 = rsp_rdata;
    chk("hold_first", rd0, 32'hABCD3344);
    req_we = 1; req_addr = 32'h20; req_wdata = 32'h55555555; req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'h1);
      chk("hold_rdata", rsp_rdata, rd0);
      chk("hold_ready", 32'(req_ready), 32'h0);
    end
    req_valid = 0; rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("release_ready", 32'(req_ready), 32'h1);
    do_req(0, 32'h20, 2'b10, 0, 0, 0, rd, er, lat);
    chk("hold_no_accept", rd, 32'h600DF00D);

    // Reset during WAIT: store sticks, response discarded.
    req_we = 1; req_addr = 32'h8; req_size = 2'b10; req_wdata = 32'h12345678; req_valid = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    #2 rst = 1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    #2 rst = 0;
    repeat (4) @(negedge clk);
    chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
    do_req(0, 32'h8, 2'b10, 0, 0, 0, rd, er, lat);
`ifdef DMEM_CLEAR_EN
    chk("rst_store_cleared", rd, 32'h0);
`else
    chk("rst_store_kept", rd, 32'h12345678);
`endif

    // Random traffic, checked by the compare process.
    for (int t = 0; t < 150; t++) begin
      logic [1:0] sz;
      int         idx, lane;
      idx  = $urandom_range(0, DEPTH + 3);
      lane = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0;
      sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_req(1'($urandom_range(0, 1)), 32'(idx * 4 + lane), sz, 1'($urandom_range(0, 1)),
             $urandom, $urandom_range(0, 3), rd, er, lat);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
